// File: rtl/dm_responder_if.sv
// MEM-stage data-memory request/response bundle shared by pipeline and responder.
// Latency: none, wires only.
// Backpressure: carried by mem_stall from the responder back to the MEM stage.
interface dm_responder_if;
    logic        MemEn;
    logic        MemWriteEn;
    logic [3:0]  Mem_sel;
    logic [31:0] addr;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        mem_stall;
    logic        mem_ready;
    logic        addr_err;

    // MEM stage side: issues requests, consumes stall/ready/read data.
    modport master (
        output MemEn, MemWriteEn, Mem_sel, addr, data_i,
        input  data_o, mem_stall, mem_ready, addr_err
    );

    // Responder side.
    modport slave (
        input  MemEn, MemWriteEn, Mem_sel, addr, data_i,
        output data_o, mem_stall, mem_ready, addr_err
    );
endinterface

// File: rtl/dm_responder.sv
// Wait-state data-memory responder in front of a single-port 32-bit word RAM.
// Latency: mem_ready pulses WAIT_CYCLES+1 cycles after the request is seen in IDLE.
// Backpressure: mem_stall holds the pipeline from request acceptance until the RESP cycle.
module dm_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rstn,
    dm_responder_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } state_t;

    localparam int         DEPTH     = 1 << ADDR_W;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
    localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                req_we_q, req_we_d;
    logic [3:0]          req_sel_q, req_sel_d;
    logic [ADDR_W-1:0]   req_idx_q, req_idx_d;
    logic                req_oor_q, req_oor_d;
    logic [31:0]         req_dat_q, req_dat_d;
    logic [31:0]         data_o_q, data_o_d;
    logic                mem_ready_q, mem_ready_d;
    logic                addr_err_q, addr_err_d;

    logic [31:0]         mem_array [DEPTH];

    // Decoded view of the live bus request.
    logic [ADDR_W-1:0]   in_idx;
    logic                in_oor;
    logic                unused_addr_lsb;

    // Access actually performed on the edge entering RESP.
    logic                to_resp;
    logic                acc_we;
    logic [3:0]          acc_sel;
    logic [ADDR_W-1:0]   acc_idx;
    logic                acc_oor;
    logic [31:0]         acc_dat;
    logic                mem_wr_en;
    logic [31:0]         mem_rd_word;

    // Byte offset within the word is irrelevant: all accesses are word-aligned.
    assign in_idx          = bus.addr[ADDR_W+1:2];
    assign in_oor          = |bus.addr[31:ADDR_W+2];
    assign unused_addr_lsb = ^bus.addr[1:0];

    // Access source: the live bus only when going straight IDLE->RESP, otherwise the captured request.
    always_comb begin
        acc_we  = req_we_q;
        acc_sel = req_sel_q;
        acc_idx = req_idx_q;
        acc_oor = req_oor_q;
        acc_dat = req_dat_q;
        if (state_q == ST_IDLE) begin
            acc_we  = bus.MemWriteEn;
            acc_sel = bus.Mem_sel;
            acc_idx = in_idx;
            acc_oor = in_oor;
            acc_dat = bus.data_i;
        end
    end

    // Next-state, wait counter, request capture and response registers.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_we_d    = req_we_q;
        req_sel_d   = req_sel_q;
        req_idx_d   = req_idx_q;
        req_oor_d   = req_oor_q;
        req_dat_d   = req_dat_q;
        to_resp     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.MemEn) begin
                    req_we_d  = bus.MemWriteEn;
                    req_sel_d = bus.Mem_sel;
                    req_idx_d = in_idx;
                    req_oor_d = in_oor;
                    req_dat_d = bus.data_i;
                    if (NO_WAIT) begin
                        state_d = ST_RESP;
                        to_resp = 1'b1;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                // <= also catches a zero count, so BUSY can never wrap and hang.
                if (cnt_q <= 4'd1) begin
                    state_d = ST_RESP;
                    cnt_d   = 4'd0;
                    to_resp = 1'b1;
                end
            end
            ST_RESP: begin
                // Request inputs are deliberately ignored here.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        data_o_d    = data_o_q;
        mem_ready_d = to_resp;
        addr_err_d  = to_resp & acc_oor;
        if (to_resp && !acc_we) begin
            data_o_d = acc_oor ? 32'd0 : mem_rd_word;
        end
    end

    // A reset on the committing edge must abandon the write, hence rstn in the enable.
    assign mem_wr_en   = rstn & to_resp & acc_we & ~acc_oor;
    assign mem_rd_word = mem_array[acc_idx];

    // State and response registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            req_we_q    <= 1'b0;
            req_sel_q   <= 4'd0;
            req_idx_q   <= '0;
            req_oor_q   <= 1'b0;
            req_dat_q   <= 32'd0;
            data_o_q    <= 32'd0;
            mem_ready_q <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_we_q    <= req_we_d;
            req_sel_q   <= req_sel_d;
            req_idx_q   <= req_idx_d;
            req_oor_q   <= req_oor_d;
            req_dat_q   <= req_dat_d;
            data_o_q    <= data_o_d;
            mem_ready_q <= mem_ready_d;
            addr_err_q  <= addr_err_d;
        end
    end

    // Word RAM with per-byte-lane write enables; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_sel[i]) begin
                    mem_array[acc_idx][8*i +: 8] <= acc_dat[8*i +: 8];
                end
            end
        end
    end

    assign bus.data_o    = data_o_q;
    assign bus.mem_ready = mem_ready_q;
    assign bus.addr_err  = addr_err_q;
    assign bus.mem_stall = ((state_q == ST_IDLE) && bus.MemEn) || (state_q == ST_BUSY);

endmodule
